button_conditioner: RTL and testbench

- Front-end stage that feeds the turn-signal/hazard state machine. Takes the raw active-low board buttons (left, right, haz).
- Per button: 2-flop synchronization, then a counter-based debounce. Produces clean active-low levels and one-cycle press pulses.
- Sticky per-button request bits hold a press until the next step tick. The block also generates that step tick, a periodic one-cycle clock enable that replaces the free-running divider bit tap.

---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner: sync + debounce the three raw active-low buttons, emit press pulses,
// sticky per-button requests and a periodic step tick.
// Latency: btn_n follows a clean raw edge after 2+DB_CYCLES clk; press coincides with btn_n falling.
// Backpressure: none; pend holds a press until the next tick so the consumer never misses one.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   btn_n_raw  raw buttons, active-low: [0]=left, [1]=right, [2]=haz
//   btn_n      debounced levels, active-low, same bit order
//   press      one-cycle pulse per bit when a debounced level falls 1->0
//   pend       sticky press request per bit, cleared on the edge after tick
//   tick       one-cycle step enable, once every TICK_DIV cycles
//
// DB_CYCLES and TICK_DIV are both expected to be >= 2.
module button_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int TICK_DIV  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_n_raw,
    output logic [2:0] btn_n,
    output logic [2:0] press,
    output logic [2:0] pend,
    output logic       tick
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        STABLE_HI,
        CHK_LO,
        STABLE_LO,
        CHK_HI
    } db_state_t;

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    db_state_t     state     [3];
    db_state_t     state_nxt [3];
    logic [CW-1:0] cnt       [3];
    logic [CW-1:0] cnt_nxt   [3];
    logic [2:0]    press_nxt;
    logic [TW-1:0] tcnt;

    // Two-flop synchronizer; resets to the released level so nothing looks pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= btn_n_raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce. The counter starts at 1 on entry to a CHK state, so the
    // entry sample counts toward the DB_CYCLES consecutive samples. It is cleared on
    // every transition and therefore never has to wrap.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b0;
            case (state[i])
                STABLE_HI: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = CHK_LO;
                        cnt_nxt[i]   = CW'(1);
                    end
                end
                CHK_LO: begin
                    if (sync2[i]) begin
                        state_nxt[i] = STABLE_HI;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = STABLE_LO;
                        press_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CW'(1);
                    end
                end
                STABLE_LO: begin
                    if (sync2[i]) begin
                        state_nxt[i] = CHK_HI;
                        cnt_nxt[i]   = CW'(1);
                    end
                end
                CHK_HI: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = STABLE_LO;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = STABLE_HI;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CW'(1);
                    end
                end
                default: begin
                    state_nxt[i] = STABLE_HI;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                state[i] <= STABLE_HI;
                cnt[i]   <= '0;
            end
            press <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            press <= press_nxt;
        end
    end

    // The debounced level is a pure decode of the registered state: low once accepted
    // as pressed, and it stays low while a release is still being qualified.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_n[i] = !((state[i] == STABLE_LO) || (state[i] == CHK_HI));
        end
    end

    // Step tick: registered compare, so tick rises on the edge where tcnt wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TICK_LAST);
            tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
        end
    end

    // Request latch: set has priority over the tick clear, so a press landing on a
    // tick cycle is carried to the next tick instead of being dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 3'b000;
        end else begin
            pend <= press | (pend & ~{3{tick}});
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn_n_raw;
    logic [2:0] btn_n;
    logic [2:0] press;
    logic [2:0] pend;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DB_CYCLES(4),
        .TICK_DIV (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_n_raw(btn_n_raw),
        .btn_n    (btn_n),
        .press    (press),
        .pend     (pend),
        .tick     (tick)
    );

    typedef struct {
        logic [2:0] raw;
        int         n;
        logic [2:0] btn;
        logic [2:0] prs;
        logic [2:0] pnd;
    } seg_t;

    seg_t tbl[$];

    function automatic void add(input logic [2:0] raw, input int n,
                                input logic [2:0] b, input logic [2:0] p, input logic [2:0] d);
        seg_t s;
        s.raw = raw;
        s.n   = n;
        s.btn = b;
        s.prs = p;
        s.pnd = d;
        tbl.push_back(s);
    endfunction

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // Hold raw for n edges; after each edge btn_n/press/pend must match, and tick must be
    // high exactly on multiples of 16 cycles since reset release.
    task automatic seg(input logic [2:0] raw, input int n,
                       input logic [2:0] b, input logic [2:0] p, input logic [2:0] d);
        logic [2:0] tk;
        for (int k = 0; k < n; k++) begin
            btn_n_raw = raw;
            @(posedge clk);
            #1;
            cyc++;
            tk = (cyc % 16 == 0) ? 3'b001 : 3'b000;
            chk("btn_n", btn_n, b);
            chk("press", press, p);
            chk("pend", pend, d);
            chk("tick", {2'b00, tick}, tk);
        end
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            btn_n_raw = 3'b000;
            @(posedge clk);
            #1;
            chk("rst_btn_n", btn_n, 3'b111);
            chk("rst_press", press, 3'b000);
            chk("rst_pend", pend, 3'b000);
            chk("rst_tick", {2'b00, tick}, 3'b000);
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset     = 1'b1;
        btn_n_raw = 3'b000;

        // Cycle numbers in the comments count edges after reset release.
        // All pressed through reset: accepted 6 cycles after release.
        add(3'b000, 5, 3'b111, 3'b000, 3'b000);  // 1-5
        add(3'b000, 1, 3'b000, 3'b111, 3'b000);  // 6
        add(3'b111, 5, 3'b000, 3'b000, 3'b111);  // 7-11 release all
        add(3'b111, 5, 3'b111, 3'b000, 3'b111);  // 12-16, tick at 16
        // Clean left press applied at 17.
        add(3'b110, 5, 3'b111, 3'b000, 3'b000);  // 17-21
        add(3'b110, 1, 3'b110, 3'b001, 3'b000);  // 22
        add(3'b110, 10, 3'b110, 3'b000, 3'b001); // 23-32, tick at 32
        // Right bounces: three low samples then high, ten times (33-72).
        for (int r = 0; r < 10; r++) begin
            add(3'b100, 3, 3'b110, 3'b000, 3'b000);
            add(3'b110, 1, 3'b110, 3'b000, 3'b000);
        end
        add(3'b110, 4, 3'b110, 3'b000, 3'b000);  // 73-76 settle
        // Left release applied at 77.
        add(3'b111, 5, 3'b110, 3'b000, 3'b000);  // 77-81
        add(3'b111, 4, 3'b111, 3'b000, 3'b000);  // 82-85
        // Haz + left together at 86.
        add(3'b010, 5, 3'b111, 3'b000, 3'b000);  // 86-90
        add(3'b010, 1, 3'b010, 3'b101, 3'b000);  // 91
        add(3'b010, 5, 3'b010, 3'b000, 3'b101);  // 92-96, tick at 96
        add(3'b111, 5, 3'b010, 3'b000, 3'b000);  // 97-101
        add(3'b111, 5, 3'b111, 3'b000, 3'b000);  // 102-106
        // Right press landing on the tick at 112.
        add(3'b101, 5, 3'b111, 3'b000, 3'b000);  // 107-111
        add(3'b101, 1, 3'b101, 3'b010, 3'b000);  // 112
        add(3'b101, 16, 3'b101, 3'b000, 3'b010); // 113-128, tick at 128
        add(3'b101, 2, 3'b101, 3'b000, 3'b000);  // 129-130
        // Two right presses between ticks 144 and 160 collapse into one request.
        add(3'b111, 5, 3'b101, 3'b000, 3'b000);  // 131-135
        add(3'b111, 4, 3'b111, 3'b000, 3'b000);  // 136-139
        add(3'b101, 5, 3'b111, 3'b000, 3'b000);  // 140-144
        add(3'b101, 1, 3'b101, 3'b010, 3'b000);  // 145
        add(3'b111, 5, 3'b101, 3'b000, 3'b010);  // 146-150
        add(3'b111, 1, 3'b111, 3'b000, 3'b010);  // 151
        add(3'b101, 5, 3'b111, 3'b000, 3'b010);  // 152-156
        add(3'b101, 1, 3'b101, 3'b010, 3'b010);  // 157
        add(3'b101, 3, 3'b101, 3'b000, 3'b010);  // 158-160, tick at 160
        add(3'b101, 3, 3'b101, 3'b000, 3'b000);  // 161-163

        reset_cycles(3);
        foreach (tbl[j]) begin
            seg(tbl[j].raw, tbl[j].n, tbl[j].btn, tbl[j].prs, tbl[j].pnd);
        end

        // Reset in the middle of a debounce and tick period: all progress is discarded.
        seg(3'b000, 4, 3'b101, 3'b000, 3'b000);  // 164-167, left/haz still qualifying
        reset_cycles(1);
        seg(3'b000, 5, 3'b111, 3'b000, 3'b000);  // 1-5
        seg(3'b000, 1, 3'b000, 3'b111, 3'b000);  // 6
        seg(3'b000, 10, 3'b000, 3'b000, 3'b111); // 7-16, tick at 16
        seg(3'b000, 1, 3'b000, 3'b000, 3'b000);  // 17

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
